mult_datapath: RTL

Register/arithmetic datapath for the 8-bit signed add-shift multiplier. It consumes the per-cycle command strobes from the multiplier control FSM: clearA, clearB, loadA, loadB, shift and sub. It holds the partial product A, the multiplier B and the sign-extension bit X. It returns bout (the current multiplier LSB) and a shift-count status so the FSM can branch and terminate. After WIDTH add/sub-shift steps, {A,B} holds the 2*WIDTH-bit signed product.

---
 rtl/mult_datapath.sv | 107 ++++++++++
 1 files changed

// File: rtl/mult_datapath.sv
// Register/arithmetic datapath for the signed add-shift multiplier: partial product A,
// multiplier B, extension bit X and a saturating shift counter, driven by FSM command strobes.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           sw,
  input  logic                       clearA,
  input  logic                       clearB,
  input  logic                       loadA,
  input  logic                       loadB,
  input  logic                       shift,
  input  logic                       sub,
  output logic [WIDTH-1:0]           Aval,
  output logic [WIDTH-1:0]           Bval,
  output logic                       X,
  output logic                       bout,
  output logic [$clog2(WIDTH):0]     shift_cnt,
  output logic                       last
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             x_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_sw;
  logic [WIDTH:0]   sum;
  logic             a_src_lsb;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic             x_d;
  logic [CW-1:0]    cnt_d;

  // Both operands sign-extended to WIDTH+1 bits so the add/sub can never overflow.
  assign ext_a  = {a_q[WIDTH-1], a_q};
  assign ext_sw = {sw[WIDTH-1], sw};
  assign sum    = sub ? (ext_a - ext_sw) : (ext_a + ext_sw);

  // A clear discards the add, so B then shifts in the pre-clear A[0].
  assign a_src_lsb = (loadA && !clearA) ? sum[0] : a_q[0];

  always_comb begin
    a_d = a_q;
    x_d = x_q;
    if (clearA) begin
      a_d = '0;
      x_d = 1'b0;
    end else if (loadA && shift) begin
      x_d = sum[WIDTH];
      a_d = {sum[WIDTH], sum[WIDTH-1:1]};
    end else if (loadA) begin
      {x_d, a_d} = sum;
    end else if (shift) begin
      a_d = {x_q, a_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    b_d = b_q;
    if (clearB) begin
      b_d = '0;
    end else if (loadB) begin
      b_d = sw;
    end else if (shift) begin
      b_d = {a_src_lsb, b_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clearB || loadB) begin
      cnt_d = '0;
    end else if (shift && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  assign Aval      = a_q;
  assign Bval      = b_q;
  assign X         = x_q;
  assign bout      = b_q[0];
  assign shift_cnt = cnt_q;
  assign last      = (cnt_q == CNT_LAST);

endmodule
